// File: rtl/vx_wb_arbiter.sv
// Writeback arbiter: round-robin grant among requesters with packet locking
// (sop..eop) and a single registered output stage of latency 1.
module vx_wb_arbiter #(
   parameter  int unsigned NUM_REQS   = 4,
   parameter  int unsigned DATA_WIDTH = 128,
   localparam int unsigned SEL_W      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQS-1:0]            req_valid_in,
   input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data_in,
   input  logic [NUM_REQS-1:0]            req_sop_in,
   input  logic [NUM_REQS-1:0]            req_eop_in,
   output logic [NUM_REQS-1:0]            req_ready_out,
   output logic                           wb_valid_out,
   output logic [DATA_WIDTH-1:0]          wb_data_out,
   output logic                           wb_sop_out,
   output logic                           wb_eop_out,
   output logic [SEL_W-1:0]               wb_sel_out
);

   typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

   state_e                  state_q, state_d;
   logic [SEL_W-1:0]        owner_q, owner_d;
   logic [SEL_W-1:0]        last_q, last_d;
   logic [SEL_W-1:0]        start_c, grant_c, src_c;
   logic                    grant_found_c;
   int unsigned             dist_c, best_c;
   logic [NUM_REQS-1:0]     ready_c;
   logic                    fire_c;
   logic [DATA_WIDTH-1:0]   data_c;
   logic                    sop_c, eop_c;

   logic                    wb_valid_q, wb_valid_d;
   logic [DATA_WIDTH-1:0]   wb_data_q, wb_data_d;
   logic                    wb_sop_q, wb_sop_d;
   logic                    wb_eop_q, wb_eop_d;
   logic [SEL_W-1:0]        wb_sel_q, wb_sel_d;

   // Round-robin pick: smallest circular distance from last_grant+1 wins.
   always_comb begin
      start_c       = (last_q == SEL_W'(NUM_REQS - 1)) ? '0 : last_q + SEL_W'(1);
      grant_c       = '0;
      grant_found_c = 1'b0;
      dist_c        = 0;
      best_c        = 0;
      for (int unsigned j = 0; j < NUM_REQS; j++) begin
         dist_c = (j + NUM_REQS - 32'(start_c)) % NUM_REQS;
         if (req_valid_in[j] && (!grant_found_c || dist_c < best_c)) begin
            grant_found_c = 1'b1;
            best_c        = dist_c;
            grant_c       = SEL_W'(j);
         end
      end
   end

   // Lock FSM next state, ready generation and output stage next values.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      ready_c    = '0;
      data_c     = '0;
      sop_c      = 1'b0;
      eop_c      = 1'b0;
      src_c      = (state_q == ST_LOCKED) ? owner_q : grant_c;

      if (!reset && (state_q == ST_LOCKED || grant_found_c)) begin
         for (int unsigned j = 0; j < NUM_REQS; j++) begin
            ready_c[j] = (32'(src_c) == j);
         end
      end

      for (int unsigned j = 0; j < NUM_REQS; j++) begin
         if (32'(src_c) == j) begin
            data_c = req_data_in[j*DATA_WIDTH +: DATA_WIDTH];
            sop_c  = req_sop_in[j];
            eop_c  = req_eop_in[j];
         end
      end

      fire_c     = |(req_valid_in & ready_c);
      wb_valid_d = fire_c;
      wb_data_d  = fire_c ? data_c : wb_data_q;
      wb_sop_d   = fire_c ? sop_c  : wb_sop_q;
      wb_eop_d   = fire_c ? eop_c  : wb_eop_q;
      wb_sel_d   = fire_c ? src_c  : wb_sel_q;

      // sop is forwarded only; eop alone decides lock and release.
      if (fire_c) begin
         if (eop_c) begin
            state_d = ST_IDLE;
            last_d  = src_c;
         end else begin
            state_d = ST_LOCKED;
            owner_d = src_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         owner_q    <= '0;
         last_q     <= SEL_W'(NUM_REQS - 1);
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         wb_sop_q   <= 1'b0;
         wb_eop_q   <= 1'b0;
         wb_sel_q   <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         wb_valid_q <= wb_valid_d;
         wb_data_q  <= wb_data_d;
         wb_sop_q   <= wb_sop_d;
         wb_eop_q   <= wb_eop_d;
         wb_sel_q   <= wb_sel_d;
      end
   end

   assign req_ready_out = ready_c;
   assign wb_valid_out  = wb_valid_q;
   assign wb_data_out   = wb_data_q;
   assign wb_sop_out    = wb_sop_q;
   assign wb_eop_out    = wb_eop_q;
   assign wb_sel_out    = wb_sel_q;

endmodule

// File: tb/tb_vx_wb_arbiter.sv
// Bench for vx_wb_arbiter: directed vector table, hand sequences, and random
// traffic against a packet-level reference model; plus a NUM_REQS=1 instance.
module tb_vx_wb_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  valid, sop, eop, ready;
   logic [63:0] data;
   logic        wb_v, wb_sop, wb_eop;
   logic [15:0] wb_data;
   logic [1:0]  wb_sel;

   logic        v1, s1, e1, r1;
   logic [15:0] d1;
   logic        o_v1, o_s1, o_e1;
   logic [15:0] o_d1;
   logic [0:0]  o_sel1;

   int n_checks = 0;
   int n_err    = 0;

   vx_wb_arbiter #(.NUM_REQS(4), .DATA_WIDTH(16)) dut (
      .clk(clk), .reset(rst),
      .req_valid_in(valid), .req_data_in(data),
      .req_sop_in(sop), .req_eop_in(eop), .req_ready_out(ready),
      .wb_valid_out(wb_v), .wb_data_out(wb_data),
      .wb_sop_out(wb_sop), .wb_eop_out(wb_eop), .wb_sel_out(wb_sel)
   );

   vx_wb_arbiter #(.NUM_REQS(1), .DATA_WIDTH(16)) dut1 (
      .clk(clk), .reset(rst),
      .req_valid_in(v1), .req_data_in(d1),
      .req_sop_in(s1), .req_eop_in(e1), .req_ready_out(r1),
      .wb_valid_out(o_v1), .wb_data_out(o_d1),
      .wb_sop_out(o_s1), .wb_eop_out(o_e1), .wb_sel_out(o_sel1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: packet ownership plus priority pointer.
   bit          m_locked;
   int          m_owner, m_last;
   logic        exp_v, exp_sop, exp_eop;
   logic [15:0] exp_data;
   logic [1:0]  exp_sel;
   logic [3:0]  last_ready;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] m_ready();
      logic [1:0] idx;
      if (rst) return 4'b0;
      if (m_locked) return 4'(1 << m_owner);
      for (int k = 1; k <= 4; k++) begin
         idx = 2'((m_last + k) % 4);
         if (valid[idx]) return 4'(1 << idx);
      end
      return 4'b0;
   endfunction

   task automatic m_update(input logic [3:0] er);
      int idx;
      if (rst) begin
         m_locked = 0; m_last = 3; m_owner = 0;
         exp_v = 0; exp_data = '0; exp_sop = 0; exp_eop = 0; exp_sel = '0;
      end else begin
         exp_v = |(valid & er);
         if (exp_v) begin
            idx = 0;
            for (int k = 0; k < 4; k++) if (er[k]) idx = k;
            exp_data = data[idx*16 +: 16];
            exp_sop  = sop[idx];
            exp_eop  = eop[idx];
            exp_sel  = 2'(idx);
            if (eop[idx]) begin m_locked = 0; m_last = idx; end
            else begin m_locked = 1; m_owner = idx; end
         end
      end
   endtask

   // One clock: ready checked mid-cycle, registered outputs checked after the edge.
   task automatic cycle();
      logic [3:0] er;
      @(negedge clk);
      er = m_ready();
      last_ready = ready;
      chk("ready", 64'(ready), 64'(er));
      @(posedge clk);
      m_update(er);
      #1;
      chk("wb_out", {39'b0, wb_v, wb_sop, wb_eop, wb_sel, wb_data},
                    {39'b0, exp_v, exp_sop, exp_eop, exp_sel, exp_data});
   endtask

   typedef struct {
      logic [3:0] valid, sop, eop, exp_ready;
      logic       exp_v;
      logic [1:0] exp_sel;
      logic       exp_sop, exp_eop;
   } vec_t;

   vec_t vecs[16];

   initial begin
      vecs[0]  = '{4'hF, 4'hF, 4'hF, 4'b0001, 1, 0, 1, 1};
      vecs[1]  = '{4'hF, 4'hF, 4'hF, 4'b0010, 1, 1, 1, 1};
      vecs[2]  = '{4'hF, 4'hF, 4'hF, 4'b0100, 1, 2, 1, 1};
      vecs[3]  = '{4'hF, 4'hF, 4'hF, 4'b1000, 1, 3, 1, 1};
      vecs[4]  = '{4'h3, 4'hF, 4'hF, 4'b0001, 1, 0, 1, 1};
      vecs[5]  = '{4'h3, 4'hF, 4'hF, 4'b0010, 1, 1, 1, 1};
      vecs[6]  = '{4'hF, 4'b0100, 4'b1011, 4'b0100, 1, 2, 1, 0};
      vecs[7]  = '{4'hF, 4'b0000, 4'b1011, 4'b0100, 1, 2, 0, 0};
      vecs[8]  = '{4'hF, 4'b0000, 4'hF,    4'b0100, 1, 2, 0, 1};
      vecs[9]  = '{4'hF, 4'hF, 4'hF, 4'b1000, 1, 3, 1, 1};
      vecs[10] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 1, 1, 1, 0};
      vecs[11] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 0, 1, 1, 0};
      vecs[12] = '{4'b1101, 4'b0000, 4'hF,    4'b0010, 0, 1, 1, 0};
      vecs[13] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 1, 0, 0};
      vecs[14] = '{4'hF, 4'b0000, 4'hF, 4'b0010, 1, 1, 0, 1};
      vecs[15] = '{4'hF, 4'hF, 4'hF, 4'b0100, 1, 2, 1, 1};

      rst = 1; valid = 0; sop = 0; eop = 0; data = 0;
      v1 = 0; s1 = 0; e1 = 0; d1 = 0;
      m_locked = 0; m_last = 3; m_owner = 0;
      exp_v = 0; exp_data = 0; exp_sop = 0; exp_eop = 0; exp_sel = 0;
      cycle();
      cycle();
      rst = 0;

      // Directed vector table: rotation, 3-beat lock, owner gap
      data = 64'h0D03_0D02_0D01_0D00;
      for (int i = 0; i < 16; i++) begin
         valid = vecs[i].valid; sop = vecs[i].sop; eop = vecs[i].eop;
         cycle();
         chk($sformatf("vec%0d_ready", i), 64'(last_ready), 64'(vecs[i].exp_ready));
         chk($sformatf("vec%0d_out", i), {60'b0, wb_v, wb_sel, wb_eop},
             {60'b0, vecs[i].exp_v, vecs[i].exp_sel, vecs[i].exp_eop});
         chk($sformatf("vec%0d_sop", i), 64'(wb_sop), 64'(vecs[i].exp_sop));
      end

      // Reset while requester 0 holds the lock after beat 1 of 3
      valid = 4'b0001; sop = 4'b0001; eop = 4'b0000;
      cycle();
      chk("lock_beat1_ready", 64'(last_ready), 64'b0001);
      rst = 1; valid = 4'b0011; sop = 4'b0000; eop = 4'b0010;
      cycle();
      chk("rst_ready", 64'(last_ready), 64'b0);
      chk("rst_out", {38'b0, wb_v, wb_sop, wb_eop, wb_sel, wb_data}, 64'b0);
      cycle();
      rst = 0; valid = 4'b0010; sop = 4'b0010; eop = 4'b0010;
      cycle();
      chk("post_rst_ready", 64'(last_ready), 64'b0010);
      chk("post_rst_out", {61'b0, wb_v, wb_sel}, {61'b0, 1'b1, 2'd1});

      // Only requester 3 with single beats; data held when idle
      valid = 4'b1000; sop = 4'b1000; eop = 4'b1000; data = 64'h00A5_0000_0000_0000;
      cycle();
      chk("r3_a5", 64'(wb_data), 64'hA5);
      data = 64'h005A_0000_0000_0000;
      cycle();
      chk("r3_5a", 64'(wb_data), 64'h5A);
      valid = 4'b0000;
      cycle();
      chk("r3_hold", {47'b0, wb_v, wb_data}, {47'b0, 1'b0, 16'h5A});

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         rst   = ($urandom % 64) == 0;
         valid = 4'($urandom);
         sop   = 4'($urandom);
         for (int k = 0; k < 4; k++) eop[k] = ($urandom % 3) == 0;
         data  = {$urandom, $urandom};
         cycle();
      end
      rst = 0; valid = 0;
      cycle();

      // NUM_REQS=1: 2-beat packet
      v1 = 1; s1 = 1; e1 = 0; d1 = 16'hBEEF;
      @(negedge clk); chk("n1_ready_idle", 64'(r1), 64'd1);
      @(posedge clk); #1;
      chk("n1_beat1", {44'b0, o_v1, o_sel1, o_s1, o_e1, o_d1}, {44'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF});
      v1 = 0;
      @(negedge clk); chk("n1_ready_locked", 64'(r1), 64'd1);
      @(posedge clk); #1;
      chk("n1_gap", 64'(o_v1), 64'd0);
      v1 = 1; s1 = 0; e1 = 1; d1 = 16'hCAFE;
      @(negedge clk); chk("n1_ready_b2", 64'(r1), 64'd1);
      @(posedge clk); #1;
      chk("n1_beat2", {44'b0, o_v1, o_sel1, o_s1, o_e1, o_d1}, {44'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hCAFE});
      v1 = 0;
      @(negedge clk); chk("n1_ready_idle2", 64'(r1), 64'd0);
      @(posedge clk); #1;
      chk("n1_hold", {47'b0, o_v1, o_d1}, {47'b0, 1'b0, 16'hCAFE});

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/vx_wb_arbiter.md
VX_WB_ARBITER -- requirements
Module: VX_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, meaning the number of writeback requesters (1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 128, meaning the width of the packed writeback payload (uuid, wis, tmask, PC, rd, data, cu_id) excluding sop/eop.
REQ-003 SHALL define SEL_W = max(1, clog2(NUM_REQS)).
REQ-004 SHALL have ports:
- clk  in  1  clock; single clock domain, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid_in  in  NUM_REQS  per-requester beat valid.
- req_data_in  in  NUM_REQS*DATA_WIDTH  per-requester payload; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_sop_in  in  NUM_REQS  start-of-packet flag per requester.
- req_eop_in  in  NUM_REQS  end-of-packet flag per requester.
- req_ready_out  out  NUM_REQS  per-requester accept.
- wb_valid_out  out  1  writeback beat valid; no backpressure.
- wb_data_out  out  DATA_WIDTH  writeback payload.
- wb_sop_out  out  1  forwarded sop.
- wb_eop_out  out  1  forwarded eop.
- wb_sel_out  out  SEL_W  index of the requester that sourced the current output beat.

Function
REQ-005 SHALL accept a beat from requester i in a cycle only when req_valid_in[i] and req_ready_out[i] are both 1 (a "fire").
REQ-006 SHALL assert at most one req_ready_out bit in any cycle.
REQ-007 SHALL implement two states:
- IDLE: no packet is in progress.
- LOCKED: owner = requester that started a packet whose eop has not yet fired.
REQ-008 In IDLE, SHALL grant round-robin among requesters with req_valid_in=1:
- search order starts at (last_grant+1) mod NUM_REQS;
- the first valid requester found gets req_ready_out=1 in the same cycle (combinational);
- no requester valid -> all ready bits 0.
REQ-009 In IDLE, when the granted fire has eop=0, SHALL go to LOCKED with owner = granted index next cycle.
REQ-010 In IDLE, a fire with eop=1 (single-beat packet) SHALL keep the state IDLE and set last_grant = granted index.
REQ-011 In LOCKED:
- req_ready_out[owner] SHALL be 1 regardless of req_valid_in[owner];
- all other ready bits SHALL be 0;
- other requesters' valid SHALL have no effect.
REQ-012 In LOCKED, an owner fire with eop=1 SHALL return the state to IDLE and set last_grant = owner; an owner fire with eop=0 SHALL stay LOCKED.
REQ-013 SHALL forward sop unchecked: sop=1 while LOCKED, or sop=0 in IDLE, passes through and does not alter the state.
REQ-014 SHALL register the output with fixed latency 1:
- wb_valid_out(t+1) = fire(t);
- wb_data_out, wb_sop_out, wb_eop_out, wb_sel_out are loaded from the firing requester on fire;
- they hold their previous value when there is no fire.
REQ-015 SHALL sustain one beat per cycle: back-to-back beats from the same or different requesters produce consecutive output beats with no bubble.
REQ-016 With NUM_REQS=1:
- req_ready_out[0] = req_valid_in[0] in IDLE and 1 in LOCKED;
- wb_sel_out is constant 0.
REQ-017 SHALL not drop, duplicate or reorder beats of any single requester, and SHALL not interleave beats of two packets on the output.

Reset
REQ-018 On reset=1 at a clock edge, SHALL set:
- state = IDLE;
- last_grant = NUM_REQS-1, so requester 0 has first priority;
- wb_valid_out = 0 and wb_sop_out = 0 and wb_eop_out = 0;
- wb_data_out = 0 and wb_sel_out = 0.
REQ-019 While reset=1, SHALL drive all req_ready_out bits to 0.
REQ-020 Reset during LOCKED SHALL abandon the packet and clear the lock; arbitration restarts from requester 0 in the first cycle after reset deasserts.

Verification
REQ-021 Bench SHALL cover these directed scenarios:
- After reset, req_valid_in=4'b1111, all eop=1, held 4 cycles -> grants 0,1,2,3 in order; wb_sel_out 0,1,2,3 in cycles 2-5; wb_valid_out=1 each of those cycles.
- Requester 2 sends a 3-beat packet (sop/eop 10,00,01) while requesters 0,1,3 are valid -> req_ready_out=4'b0100 for all 3 beats; output beats contiguous with wb_sel_out=2; next grant goes to 3.
- Requester 1 locked and drops valid for 2 cycles mid-packet -> req_ready_out stays 4'b0010; no output beats in those cycles; the packet resumes after the gap and then completes.
- Reset asserted while requester 0 holds the lock after beat 1 of 3 -> wb_valid_out=0 and ready=0 during reset; after reset requester 1 with eop=1 is granted in the first cycle.
- Only requester 3 valid with single beats, data=0xA5 then 0x5A -> wb_data_out is 0xA5 then 0x5A, 1 cycle after each fire; wb_data_out holds 0x5A when idle.
- NUM_REQS=1, 2-beat packet -> output beats with wb_sel_out=0 and sop/eop forwarded unchanged.
